sd_system: RTL and testbench

- Self-contained "digital system": a control-unit FSM plus a small datapath.
- On a start pulse (xs), it computes the sum of squares 1²+2²+…+N² using only repeated addition, then raises fin.
- Top-level block of the lab design. Intended use: exercise with a start pulse and observe fin and the optional result bus.

---
 rtl/sd_system.sv | 111 +++++++++++
 tb/tb_sd_system.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_system.sv
// sd_system: control FSM plus a small datapath computing 1^2 + 2^2 + ... + N^2
// by repeated addition. fin is high while res holds the final sum.
// Optional feature macro: SD_SYSTEM_BUSY_EN adds a busy output that is high
// in INIT, MUL and ACC.
module sd_system #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         xs,
  output logic         fin,
  output logic [W-1:0] res
`ifdef SD_SYSTEM_BUSY_EN
  ,
  output logic         busy
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    MUL  = 3'd2,
    ACC  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [4:0] NTERMS = 5'(N);

  state_t       state;
  logic [4:0]   i;
  logic [4:0]   k;
  logic [W-1:0] sq;
  logic [W-1:0] acc;

  assign res = acc;

  // Control FSM and datapath registers; fin (and busy) are registered
  // alongside the state so they always reflect the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      fin   <= 1'b0;
      i     <= '0;
      k     <= '0;
      sq    <= '0;
      acc   <= '0;
`ifdef SD_SYSTEM_BUSY_EN
      busy  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          fin <= 1'b0;
          if (xs) begin
            state <= INIT;
`ifdef SD_SYSTEM_BUSY_EN
            busy  <= 1'b1;
`endif
          end
        end
        INIT: begin
          i     <= 5'd1;
          k     <= '0;
          sq    <= '0;
          acc   <= '0;
          state <= MUL;
        end
        MUL: begin
          sq <= sq + W'(i);
          k  <= k + 5'd1;
          if (k == i - 5'd1) begin
            state <= ACC;
          end
        end
        ACC: begin
          acc <= acc + sq;
          if (i == NTERMS) begin
            state <= DONE;
            fin   <= 1'b1;
`ifdef SD_SYSTEM_BUSY_EN
            busy  <= 1'b0;
`endif
          end else begin
            i     <= i + 5'd1;
            sq    <= '0;
            k     <= '0;
            state <= MUL;
          end
        end
        DONE: begin
          if (xs) begin
            state <= INIT;
            fin   <= 1'b0;
`ifdef SD_SYSTEM_BUSY_EN
            busy  <= 1'b1;
`endif
          end
        end
        default: begin
          state <= IDLE;
          fin   <= 1'b0;
`ifdef SD_SYSTEM_BUSY_EN
          busy  <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_system.sv
// Bench for sd_system: stimulus pushes expected (completion cycle, result)
// entries into per-instance queues; monitors pop and compare on each fin rise.
module tb_sd_system;

  logic        clk;
  logic        reset;
  logic        xs8;
  logic        xs1;
  logic        fin8;
  logic        fin1;
  logic [15:0] res8;
  logic [15:0] res1;
`ifdef SD_SYSTEM_BUSY_EN
  logic        busy8;
  logic        busy1;
`endif

  sd_system #(.N(8), .W(16)) dut8 (
    .clk   (clk),
    .reset (reset),
    .xs    (xs8),
    .fin   (fin8),
    .res   (res8)
`ifdef SD_SYSTEM_BUSY_EN
    ,
    .busy  (busy8)
`endif
  );

  sd_system #(.N(1), .W(16)) dut1 (
    .clk   (clk),
    .reset (reset),
    .xs    (xs1),
    .fin   (fin1),
    .res   (res1)
`ifdef SD_SYSTEM_BUSY_EN
    ,
    .busy  (busy1)
`endif
  );

  typedef struct {
    string       name;
    int unsigned cyc;
    logic [15:0] res;
  } exp_t;

  exp_t        q8[$];
  exp_t        q1[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;
  int unsigned busy_cnt1 = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor for the N=8 instance: each fin rise must match the oldest expectation.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (fin8 === 1'b1 && !prev) begin
        if (q8.size() == 0) begin
          check("unexpected_fin8", 32'(q8.size()), 32'd1);
        end else begin
          e = q8.pop_front();
          check({e.name, "_cycle"}, cyc, e.cyc);
          check({e.name, "_res"}, 32'(res8), 32'(e.res));
        end
      end
      prev = (fin8 === 1'b1);
    end
  end

  // Monitor for the N=1 instance, also counting busy cycles when present.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
`ifdef SD_SYSTEM_BUSY_EN
      if (busy1 === 1'b1) busy_cnt1++;
`endif
      if (fin1 === 1'b1 && !prev) begin
        if (q1.size() == 0) begin
          check("unexpected_fin1", 32'(q1.size()), 32'd1);
        end else begin
          e = q1.pop_front();
          check({e.name, "_cycle"}, cyc, e.cyc);
          check({e.name, "_res"}, 32'(res1), 32'(e.res));
        end
      end
      prev = (fin1 === 1'b1);
    end
  end

  task automatic push8(input string name, input int unsigned c);
    exp_t e;
    e.name = name;
    e.cyc  = c;
    e.res  = 16'd204;
    q8.push_back(e);
  endtask

  // One-edge start pulse; returns at the negedge right after the sampling edge E0.
  task automatic start8(input string name);
    @(negedge clk);
    xs8 = 1'b1;
    push8(name, cyc + 1 + 45);
    @(negedge clk);
    xs8 = 1'b0;
  endtask

  task automatic wait_q8(input int unsigned lim);
    int unsigned n = 0;
    while (q8.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("drain8", 32'(q8.size()), 32'd0);
    q8.delete();
  endtask

  initial begin
    int unsigned cnt;
    exp_t        e;
    reset = 1'b0;
    xs8   = 1'b1;
    xs1   = 1'b0;

    // Reset held with xs high: outputs stay cleared.
    repeat (4) begin
      @(negedge clk);
      check("rst_fin8", 32'(fin8), 32'd0);
      check("rst_res8", 32'(res8), 32'd0);
    end

    // Release with xs still high: the very next edge is E0.
    reset = 1'b1;
    push8("nominal", cyc + 1 + 45);
    @(negedge clk);
    xs8 = 1'b0;
    wait_q8(100);

    // fin and the result hold in DONE.
    cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (fin8 === 1'b1 && res8 === 16'd204) cnt++;
    end
    check("done_hold", cnt, 32'd80);

    // Restart from DONE.
    start8("restart");
    check("restart_fin_drop", 32'(fin8), 32'd0);
    @(negedge clk);
    check("restart_res_clear", 32'(res8), 32'd0);
    wait_q8(100);

    // xs held high throughout: first run unaffected, then immediate restart from DONE.
    @(negedge clk);
    cnt = cyc;
    xs8 = 1'b1;
    push8("xs_held", cnt + 1 + 45);
    push8("xs_held_restart", cnt + 1 + 46 + 45);
    repeat (92) @(negedge clk);
    xs8 = 1'b0;
    wait_q8(5);

    // Reset in the middle of a run.
    start8("aborted");
    repeat (20) @(negedge clk);
    check("midrun_acc", 32'(res8), 32'd30);
    reset = 1'b0;
    #1;
    check("midrun_rst_fin", 32'(fin8), 32'd0);
    check("midrun_rst_res", 32'(res8), 32'd0);
    if (q8.size() != 0) void'(q8.pop_back());
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start8("after_reset");
    wait_q8(100);

    // Single-term instance.
    @(negedge clk);
    xs1    = 1'b1;
    e.name = "n1";
    e.cyc  = cyc + 1 + 3;
    e.res  = 16'd1;
    q1.push_back(e);
    @(negedge clk);
    xs1 = 1'b0;
    cnt = 0;
    while (q1.size() != 0 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("drain1", 32'(q1.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("n1_hold_fin", 32'(fin1), 32'd1);
`ifdef SD_SYSTEM_BUSY_EN
    check("n1_busy_cycles", busy_cnt1, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
